rf_scoreboard: RTL and testbench
================================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 Parameter MAX_INFLIGHT, default 3, SHALL set the maximum number of issued-but-unretired writes tracked per register (range 1..3).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ds_to_es_valid  input  1  ID has a valid instruction offered to EXE.
REQ-005 es_allowin  input  1  EXE can accept; issue fires when ds_to_es_valid && es_allowin && !ds_stall.
REQ-006 ds_gr_we  input  1  the offered instruction writes a GPR.
REQ-007 ds_dest  input  5  destination GPR of the offered instruction.
REQ-008 ds_rj_re, ds_rk_re  input  1 each  source-read enables.
REQ-009 ds_rj, ds_rk  input  5 each  source GPR numbers.
REQ-010 rf_bus  input  39  writeback bus {ws_valid, rf_we, rf_waddr[4:0], rf_wdata[31:0]}; only bits 38:32 are used.
REQ-011 flush  input  1  pipeline flush; all in-flight instructions in EXE/MEM are killed.
REQ-012 ds_stall  output  1  combinational; ID must not issue this cycle.
REQ-013 busy_vec  output  32  registered; bit i = 1 when counter i is non-zero.
REQ-014 sb_error  output  1  registered, sticky protocol-error flag.

Function
REQ-015 State: 31 counters cnt[1..31], 2 bits each; GPR 0 SHALL never be tracked, and cnt[0] reads as 0.
REQ-016 issue_inc = issue fire && ds_gr_we && ds_dest != 0; increments cnt[ds_dest] by 1 at the edge.
REQ-017 retire_dec = rf_bus[38] && rf_bus[37] && rf_bus[36:32] != 0; decrements cnt[rf_bus[36:32]] by 1 at the edge.
REQ-018 issue_inc and retire_dec on the same register in the same cycle SHALL leave that counter unchanged.
REQ-019 issue_inc and retire_dec on different registers in the same cycle SHALL both apply.
REQ-020 Source hazard for src s: re_s && s != 0 && (cnt[s] - (retire_dec && rf_waddr == s)) > 0. A write retiring this cycle is treated as visible, because the regfile is write-through.
REQ-021 Dest saturation: ds_gr_we && ds_dest != 0 && cnt[ds_dest] == MAX_INFLIGHT && !(retire_dec && rf_waddr == ds_dest).
REQ-022 ds_stall = ds_to_es_valid && (rj hazard || rk hazard || dest saturation); ds_stall SHALL be 0 when ds_to_es_valid = 0.
REQ-023 ds_stall SHALL NOT depend on es_allowin, so there is no combinational loop through the EXE handshake.
REQ-024 Retire on a counter already at 0 SHALL leave it at 0 and set sb_error.
REQ-025 An increment that would exceed MAX_INFLIGHT cannot occur because ds_stall blocks it; counters SHALL never wrap.
REQ-026 flush SHALL clear all counters on the next edge, and both issue and retire SHALL be ignored in the flush cycle.
REQ-027 ds_stall SHALL still be computed from the current counters during the flush cycle.
REQ-028 busy_vec[i] = (cnt[i] != 0), updated at the same edge as the counters.
REQ-029 Latency: an issue makes its dest busy from the next cycle; a retire frees its dest in the same cycle for ds_stall and the next cycle for busy_vec.

Reset
REQ-030 While reset = 1, all counters SHALL be 0, busy_vec = 0 and sb_error = 0 at the next edge, with all other inputs ignored.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight tracking; the first post-reset retire with a non-zero waddr SHALL set sb_error only if that register's counter is 0.
REQ-032 After reset deasserts, ds_stall = 0 for any offered instruction.

Verification
REQ-033 Issue to r5, then offer a reader of r5 with EXE/MEM/WB taking 3 cycles -> ds_stall = 1 for 2 cycles, 0 in the rf_bus retire cycle for r5; busy_vec[5] falls the cycle after.
REQ-034 Issue three writes to r7 back-to-back with no retire, then offer a fourth r7 write -> ds_stall = 1 (saturation); a retire of r7 in the same cycle drops ds_stall to 0.
REQ-035 Same-cycle issue to r3 and retire of r3 with cnt[3] = 1 -> cnt[3] stays 1, busy_vec[3] = 1.
REQ-036 Writes to r0 and reads of r0 -> never stall, busy_vec[0] = 0, sb_error = 0.
REQ-037 cnt[4] = 2 and cnt[9] = 1, assert flush together with an issue to r4 -> busy_vec = 0 on the next cycle, and the issue is not recorded.
REQ-038 Retire of r12 with cnt[12] = 0 -> sb_error = 1 and holds until reset; cnt[12] stays 0.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-GPR in-flight write scoreboard for ID-stage RAW/saturation stalls
module rf_scoreboard #(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_to_es_valid,
  input  logic        es_allowin,
  input  logic        ds_gr_we,
  input  logic [4:0]  ds_dest,
  input  logic        ds_rj_re,
  input  logic        ds_rk_re,
  input  logic [4:0]  ds_rj,
  input  logic [4:0]  ds_rk,
  input  logic [38:0] rf_bus,
  input  logic        flush,
  output logic        ds_stall,
  output logic [31:0] busy_vec,
  output logic        sb_error
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_INFLIGHT);

  // Writeback bus fields; the data half is not needed for tracking.
  logic       ws_valid;
  logic       rf_we;
  logic [4:0] rf_waddr;
  logic       unused_wdata;

  assign ws_valid     = rf_bus[38];
  assign rf_we        = rf_bus[37];
  assign rf_waddr     = rf_bus[36:32];
  assign unused_wdata = ^rf_bus[31:0];

  // Counter storage for r1..r31; r0 is never written so it is not stored.
  logic [1:0] cnt_q    [1:31];
  logic [1:0] cnt_d    [1:31];
  logic [1:0] cnt_view [0:31];

  // Full 32-entry view with r0 pinned to zero so lookups never need a special case.
  always_comb begin
    cnt_view[0] = 2'd0;
    for (int i = 1; i < 32; i++) begin
      cnt_view[i] = cnt_q[i];
    end
  end

  logic       retire_dec;
  logic       issue_fire;
  logic       issue_inc;
  logic [1:0] cnt_rj;
  logic [1:0] cnt_rk;
  logic [1:0] cnt_dest;
  logic [1:0] cnt_wa;
  logic       rj_hazard;
  logic       rk_hazard;
  logic       dest_sat;
  logic       retire_err;

  assign retire_dec = ws_valid && rf_we && (rf_waddr != 5'd0);
  assign cnt_rj     = cnt_view[ds_rj];
  assign cnt_rk     = cnt_view[ds_rk];
  assign cnt_dest   = cnt_view[ds_dest];
  assign cnt_wa     = cnt_view[rf_waddr];

  // A write retiring this cycle is already visible through the write-through regfile,
  // so a source whose only outstanding write is retiring now does not stall.
  assign rj_hazard = ds_rj_re && (ds_rj != 5'd0) && (cnt_rj != 2'd0) &&
                     !((cnt_rj == 2'd1) && retire_dec && (rf_waddr == ds_rj));
  assign rk_hazard = ds_rk_re && (ds_rk != 5'd0) && (cnt_rk != 2'd0) &&
                     !((cnt_rk == 2'd1) && retire_dec && (rf_waddr == ds_rk));
  assign dest_sat  = ds_gr_we && (ds_dest != 5'd0) && (cnt_dest == MAX_CNT) &&
                     !(retire_dec && (rf_waddr == ds_dest));

  // Stall is independent of es_allowin to keep the EXE handshake loop-free.
  assign ds_stall   = ds_to_es_valid && (rj_hazard || rk_hazard || dest_sat);
  assign issue_fire = ds_to_es_valid && es_allowin && !ds_stall;
  assign issue_inc  = issue_fire && ds_gr_we && (ds_dest != 5'd0) && !flush;

  // A retire that finds nothing outstanding (and is not paired with a same-cycle issue) is a protocol error.
  assign retire_err = retire_dec && !flush && (cnt_wa == 2'd0) &&
                      !(issue_inc && (ds_dest == rf_waddr));

  // Next counter values: flush wins, a matched issue+retire cancels, retire never goes below zero.
  always_comb begin
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = 2'd0;
      end else if (issue_inc && (ds_dest == 5'(i)) && !(retire_dec && (rf_waddr == 5'(i)))) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (retire_dec && (rf_waddr == 5'(i)) && !(issue_inc && (ds_dest == 5'(i))) &&
                   (cnt_q[i] != 2'd0)) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
  end

  // Counter, busy vector and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        cnt_q[i] <= 2'd0;
      end
      busy_vec <= 32'd0;
      sb_error <= 1'b0;
    end else begin
      busy_vec[0] <= 1'b0;
      for (int i = 1; i < 32; i++) begin
        cnt_q[i]    <= cnt_d[i];
        busy_vec[i] <= (cnt_d[i] != 2'd0);
      end
      if (retire_err) begin
        sb_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb/tb_rf_scoreboard.sv - self-checking bench for rf_scoreboard
module tb_rf_scoreboard;

  localparam int MAX = 3;

  logic        clk;
  logic        reset;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic        ds_gr_we;
  logic [4:0]  ds_dest;
  logic        ds_rj_re;
  logic        ds_rk_re;
  logic [4:0]  ds_rj;
  logic [4:0]  ds_rk;
  logic        ws_valid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [38:0] rf_bus;
  logic        flush;
  logic        ds_stall;
  logic [31:0] busy_vec;
  logic        sb_error;

  assign rf_bus = {ws_valid, rf_we, rf_waddr, rf_wdata};

  rf_scoreboard #(.MAX_INFLIGHT(MAX)) dut (
    .clk(clk), .reset(reset), .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .ds_rj_re(ds_rj_re), .ds_rk_re(ds_rk_re),
    .ds_rj(ds_rj), .ds_rk(ds_rk), .rf_bus(rf_bus), .flush(flush),
    .ds_stall(ds_stall), .busy_vec(busy_vec), .sb_error(sb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_cnt [32];
  logic m_err = 1'b0;
  logic last_stall;
  logic [32:0] exp_q [$];

  function automatic logic model_stall();
    logic ret;
    logic rjh, rkh, sat;
    int hj, hk;
    ret = ws_valid && rf_we && (rf_waddr != 0);
    hj  = (ret && rf_waddr == ds_rj) ? 1 : 0;
    hk  = (ret && rf_waddr == ds_rk) ? 1 : 0;
    rjh = ds_rj_re && (ds_rj != 0) && ((m_cnt[ds_rj] - hj) > 0);
    rkh = ds_rk_re && (ds_rk != 0) && ((m_cnt[ds_rk] - hk) > 0);
    sat = ds_gr_we && (ds_dest != 0) && (m_cnt[ds_dest] == MAX) && !(ret && rf_waddr == ds_dest);
    return ds_to_es_valid && (rjh || rkh || sat);
  endfunction

  task automatic model_step(input logic st);
    logic fire, inc, dec;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      fire = ds_to_es_valid && es_allowin && !st;
      inc  = fire && ds_gr_we && (ds_dest != 0);
      dec  = ws_valid && rf_we && (rf_waddr != 0);
      if (!(inc && dec && ds_dest == rf_waddr)) begin
        if (inc) m_cnt[ds_dest] = m_cnt[ds_dest] + 1;
        if (dec) begin
          if (m_cnt[rf_waddr] == 0) m_err = 1'b1;
          else m_cnt[rf_waddr] = m_cnt[rf_waddr] - 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  // One clock: compare combinational stall mid-cycle, push expected registered state, pop after the edge.
  task automatic cycle();
    logic exp_stall;
    logic [32:0] e;
    @(negedge clk);
    exp_stall = model_stall();
    checks++;
    if (ds_stall !== exp_stall) begin
      errors++;
      $display("FAIL ds_stall cyc=%0d got %b exp %b", cyc, ds_stall, exp_stall);
    end
    last_stall = ds_stall;
    model_step(exp_stall);
    exp_q.push_back({model_busy(), m_err});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (busy_vec !== e[32:1]) begin
      errors++;
      $display("FAIL busy_vec cyc=%0d got %h exp %h", cyc, busy_vec, e[32:1]);
    end
    checks++;
    if (sb_error !== e[0]) begin
      errors++;
      $display("FAIL sb_error cyc=%0d got %b exp %b", cyc, sb_error, e[0]);
    end
    cyc++;
  endtask

  task automatic idle();
    reset = 0; ds_to_es_valid = 0; es_allowin = 1; ds_gr_we = 0; ds_dest = 0;
    ds_rj_re = 0; ds_rk_re = 0; ds_rj = 0; ds_rk = 0;
    ws_valid = 0; rf_we = 0; rf_waddr = 0; rf_wdata = 32'hdead_beef; flush = 0;
  endtask

  task automatic issue_w(input logic [4:0] d);
    ds_to_es_valid = 1; ds_gr_we = 1; ds_dest = d;
  endtask

  task automatic retire(input logic [4:0] a);
    ws_valid = 1; rf_we = 1; rf_waddr = a; rf_wdata = $urandom;
  endtask

  task automatic direct(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    idle(); reset = 1; issue_w(5'd5); retire(5'd6); ds_rj_re = 1; ds_rj = 5'd6;
    cycle(); cycle();
    direct("reset_busy0", busy_vec == 32'd0, 1'b1);
    direct("reset_err0", sb_error, 1'b0);
    idle(); ds_to_es_valid = 1; ds_rj_re = 1; ds_rj = 5'd5; ds_rk_re = 1; ds_rk = 5'd6;
    cycle();
    direct("post_reset_nostall", last_stall, 1'b0);
    idle(); cycle();
  endtask

  task automatic test_raw();
    idle(); issue_w(5'd5); cycle();
    idle(); ds_to_es_valid = 1; ds_rj_re = 1; ds_rj = 5'd5; cycle();
    direct("raw_stall1", last_stall, 1'b1);
    cycle();
    direct("raw_stall2", last_stall, 1'b1);
    direct("raw_busy5_held", busy_vec[5], 1'b1);
    retire(5'd5); cycle();
    direct("raw_retire_nostall", last_stall, 1'b0);
    direct("raw_busy5_freed", busy_vec[5], 1'b0);
    idle(); cycle();
  endtask

  task automatic test_saturation();
    idle(); issue_w(5'd7);
    for (int i = 0; i < 3; i++) cycle();
    cycle();
    direct("sat_stall", last_stall, 1'b1);
    retire(5'd7); cycle();
    direct("sat_retire_unstall", last_stall, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) begin retire(5'd7); cycle(); end
    idle(); cycle();
    direct("sat_drained", busy_vec[7], 1'b0);
  endtask

  task automatic test_same_cycle();
    idle(); issue_w(5'd3); cycle();
    issue_w(5'd3); retire(5'd3); cycle();
    direct("same_busy3", busy_vec[3], 1'b1);
    idle(); retire(5'd3); cycle();
    direct("same_drained", busy_vec[3], 1'b0);
    idle(); cycle();
  endtask

  task automatic test_r0();
    idle(); issue_w(5'd0); ds_rj_re = 1; ds_rk_re = 1; cycle(); cycle();
    retire(5'd0); cycle();
    direct("r0_nostall", last_stall, 1'b0);
    direct("r0_busy0", busy_vec[0], 1'b0);
    direct("r0_err", sb_error, 1'b0);
    idle(); cycle();
  endtask

  task automatic test_flush();
    idle(); issue_w(5'd4); cycle(); cycle();
    issue_w(5'd9); cycle();
    issue_w(5'd4); flush = 1; cycle();
    direct("flush_busy_clear", busy_vec == 32'd0, 1'b1);
    idle(); ds_to_es_valid = 1; ds_rj_re = 1; ds_rj = 5'd4; cycle();
    direct("flush_no_record", last_stall, 1'b0);
    idle(); cycle();
  endtask

  task automatic test_error();
    idle(); retire(5'd12); cycle();
    direct("err_set", sb_error, 1'b1);
    direct("err_cnt12_zero", busy_vec[12], 1'b0);
    idle(); for (int i = 0; i < 3; i++) cycle();
    direct("err_sticky", sb_error, 1'b1);
    reset = 1; cycle();
    direct("err_cleared", sb_error, 1'b0);
    idle(); cycle();
  endtask

  task automatic test_mid_reset();
    idle(); issue_w(5'd10); cycle();
    idle(); reset = 1; cycle();
    idle(); retire(5'd10); cycle();
    direct("midreset_err", sb_error, 1'b1);
    idle(); reset = 1; cycle();
    idle(); cycle();
  endtask

  task automatic test_back_to_back();
    logic [4:0] wa;
    for (int n = 0; n < 300; n++) begin
      idle();
      ds_to_es_valid = ($urandom_range(0, 3) != 0);
      es_allowin     = ($urandom_range(0, 3) != 0);
      ds_gr_we       = $urandom_range(0, 1);
      ds_dest        = 5'($urandom_range(0, 6));
      ds_rj_re       = $urandom_range(0, 1);
      ds_rk_re       = $urandom_range(0, 1);
      ds_rj          = 5'($urandom_range(0, 6));
      ds_rk          = 5'($urandom_range(0, 6));
      wa             = 5'($urandom_range(0, 6));
      if (m_cnt[wa] > 0 || $urandom_range(0, 40) == 0) retire(wa);
      flush          = ($urandom_range(0, 30) == 0);
      cycle();
    end
    idle(); cycle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    idle(); reset = 1;
    test_reset();
    test_raw();
    test_saturation();
    test_same_cycle();
    test_r0();
    test_flush();
    test_error();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
